// File: rtl/id_stage_pipe.sv
// Decode stage: register file with WB write-through, load-use bubble insertion,
// and the ID/EX pipeline register feeding the execute stage.
module id_stage_pipe #(
   parameter int          DATA_W  = 32,
   parameter int          REG_AW  = 5,
   parameter int          EX_W    = 16,
   parameter int          M_W     = 16,
   parameter int          WB_W    = 4,
   parameter int          MRD_BIT = 0,
   parameter int          SP_REG  = 29,
   parameter logic [31:0] SP_INIT = 32'h0000_03FC,
   parameter int          PC_ADJ  = 8,
   parameter int          CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ifid_ir,
   input  logic [DATA_W-1:0] ifid_pc,
   input  logic              ifid_vld,
   input  logic              isr,
   input  logic [2:0]        lisr,
   input  logic [EX_W-1:0]   ctl_ex,
   input  logic [M_W-1:0]    ctl_m,
   input  logic [WB_W-1:0]   ctl_wb,
   input  logic              flush,
   input  logic              ex_stall,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              id_stall,
   output logic              idex_vld,
   output logic [EX_W-1:0]   idex_ex,
   output logic [M_W-1:0]    idex_m,
   output logic [WB_W-1:0]   idex_wb,
   output logic [REG_AW-1:0] idex_sa,
   output logic [REG_AW-1:0] idex_ta,
   output logic [REG_AW-1:0] idex_da,
   output logic [DATA_W-1:0] idex_s,
   output logic [DATA_W-1:0] idex_t,
   output logic [DATA_W-1:0] idex_se,
   output logic [DATA_W-1:0] idex_pc,
   output logic [DATA_W-1:0] idex_ja,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam int                NREG     = 2**REG_AW;
   localparam logic [REG_AW-1:0] SP_ADDR  = REG_AW'(SP_REG);
   localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);
   localparam logic [DATA_W-1:0] PC_DEC   = DATA_W'(PC_ADJ);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] imm);
      return {{(DATA_W-16){imm[15]}}, imm};
   endfunction

   logic [DATA_W-1:0] regs [NREG];
   logic [REG_AW-1:0] s_addr, t_addr;
   logic [DATA_W-1:0] s_val, t_val;
   logic              in_isr, load_use;
   logic              unused_opcode;

   assign unused_opcode = ^ifid_ir[31:26];

   // Interrupt entry/exit always sources the stack pointer on the S port.
   assign in_isr = isr | (|lisr);
   assign s_addr = in_isr ? SP_ADDR : REG_AW'(ifid_ir[25:21]);
   assign t_addr = REG_AW'(ifid_ir[20:16]);

   // Write-through bypass; reg 0 is never written so it always reads 0.
   assign s_val = (wb_en && wb_addr == s_addr && wb_addr != '0) ? wb_data : regs[s_addr];
   assign t_val = (wb_en && wb_addr == t_addr && wb_addr != '0) ? wb_data : regs[t_addr];

   assign load_use = idex_vld && idex_m[MRD_BIT] && (idex_ta != '0) && ifid_vld &&
                     ((idex_ta == s_addr) || (idex_ta == t_addr));
   assign id_stall = ex_stall | load_use;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= (i == SP_REG) ? SP_VAL : '0;
      end else if (wb_en && wb_addr != '0) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // ID -> EX boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_vld   <= 1'b0;
         idex_ex    <= '0;
         idex_m     <= '0;
         idex_wb    <= '0;
         idex_sa    <= '0;
         idex_ta    <= '0;
         idex_da    <= '0;
         idex_s     <= '0;
         idex_t     <= '0;
         idex_se    <= '0;
         idex_pc    <= '0;
         idex_ja    <= '0;
         bubble_cnt <= '0;
      end else if (flush || (!ex_stall && load_use)) begin
         idex_vld <= 1'b0;
         idex_ex  <= '0;
         idex_m   <= '0;
         idex_wb  <= '0;
         idex_sa  <= '0;
         idex_ta  <= '0;
         idex_da  <= '0;
         idex_s   <= '0;
         idex_t   <= '0;
         idex_se  <= '0;
         idex_pc  <= '0;
         idex_ja  <= '0;
         if (!flush)
            bubble_cnt <= sat_inc(bubble_cnt);
      end else if (!ex_stall) begin
         idex_vld <= ifid_vld;
         idex_ex  <= ctl_ex;
         idex_m   <= ctl_m;
         idex_wb  <= ctl_wb;
         idex_sa  <= s_addr;
         idex_ta  <= t_addr;
         idex_da  <= REG_AW'(ifid_ir[15:11]);
         idex_s   <= s_val;
         idex_t   <= t_val;
         idex_se  <= sext16(ifid_ir[15:0]);
         idex_pc  <= isr ? ifid_pc - PC_DEC : ifid_pc;
         idex_ja  <= {ifid_pc[DATA_W-1:28], ifid_ir[25:0], 2'b00};
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic, all
// compared against a cycle-level behavioural model of the decode stage.
module tb_id_stage_pipe;

   logic        clk, rst;
   logic [31:0] ifid_ir, ifid_pc, wb_data;
   logic        ifid_vld, isr, flush, ex_stall, wb_en;
   logic [2:0]  lisr;
   logic [15:0] ctl_ex, ctl_m;
   logic [3:0]  ctl_wb;
   logic [4:0]  wb_addr;
   logic        id_stall, idex_vld;
   logic [15:0] idex_ex, idex_m, bubble_cnt;
   logic [3:0]  idex_wb;
   logic [4:0]  idex_sa, idex_ta, idex_da;
   logic [31:0] idex_s, idex_t, idex_se, idex_pc, idex_ja;

   id_stage_pipe dut (
      .clk(clk), .rst(rst), .ifid_ir(ifid_ir), .ifid_pc(ifid_pc), .ifid_vld(ifid_vld),
      .isr(isr), .lisr(lisr), .ctl_ex(ctl_ex), .ctl_m(ctl_m), .ctl_wb(ctl_wb),
      .flush(flush), .ex_stall(ex_stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .id_stall(id_stall), .idex_vld(idex_vld), .idex_ex(idex_ex), .idex_m(idex_m),
      .idex_wb(idex_wb), .idex_sa(idex_sa), .idex_ta(idex_ta), .idex_da(idex_da),
      .idex_s(idex_s), .idex_t(idex_t), .idex_se(idex_se), .idex_pc(idex_pc),
      .idex_ja(idex_ja), .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // behavioural model state
   logic [31:0] mreg [32];
   logic        m_vld;
   logic [15:0] m_ex, m_m, m_cnt;
   logic [3:0]  m_wb;
   logic [4:0]  m_sa, m_ta, m_da;
   logic [31:0] m_s, m_t, m_se, m_pc, m_ja;
   logic        obs_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
      mreg[29] = 32'h0000_03FC;
      m_vld = 0; m_ex = 0; m_m = 0; m_wb = 0; m_sa = 0; m_ta = 0; m_da = 0;
      m_s = 0; m_t = 0; m_se = 0; m_pc = 0; m_ja = 0; m_cnt = 0;
   endtask

   task automatic model_clear();
      m_vld = 0; m_ex = 0; m_m = 0; m_wb = 0; m_sa = 0; m_ta = 0; m_da = 0;
      m_s = 0; m_t = 0; m_se = 0; m_pc = 0; m_ja = 0;
   endtask

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (wb_en && wb_addr == a) return wb_data;
      return mreg[a];
   endfunction

   task automatic check_all(input string where);
      chk({where, ".vld"}, 64'(idex_vld), 64'(m_vld));
      chk({where, ".ex"},  64'(idex_ex),  64'(m_ex));
      chk({where, ".m"},   64'(idex_m),   64'(m_m));
      chk({where, ".wb"},  64'(idex_wb),  64'(m_wb));
      chk({where, ".sa"},  64'(idex_sa),  64'(m_sa));
      chk({where, ".ta"},  64'(idex_ta),  64'(m_ta));
      chk({where, ".da"},  64'(idex_da),  64'(m_da));
      chk({where, ".s"},   64'(idex_s),   64'(m_s));
      chk({where, ".t"},   64'(idex_t),   64'(m_t));
      chk({where, ".se"},  64'(idex_se),  64'(m_se));
      chk({where, ".pc"},  64'(idex_pc),  64'(m_pc));
      chk({where, ".ja"},  64'(idex_ja),  64'(m_ja));
      chk({where, ".cnt"}, 64'(bubble_cnt), 64'(m_cnt));
   endtask

   // One clock: check the combinational stall mid-cycle, advance the model, check ID/EX.
   task automatic cycle(input string where);
      logic [4:0]  sa, ta;
      logic        lu;
      logic [31:0] sv, tv;
      #4;
      sa = (isr || lisr != 3'b0) ? 5'd29 : ifid_ir[25:21];
      ta = ifid_ir[20:16];
      lu = m_vld && m_m[0] && m_ta != 0 && ifid_vld && (m_ta == sa || m_ta == ta);
      obs_stall = id_stall;
      chk({where, ".stall"}, 64'(id_stall), 64'(ex_stall || lu));
      sv = mread(sa);
      tv = mread(ta);
      @(posedge clk);
      #1;
      if (flush) model_clear();
      else if (ex_stall) ;
      else if (lu) begin
         model_clear();
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end else begin
         m_vld = ifid_vld; m_ex = ctl_ex; m_m = ctl_m; m_wb = ctl_wb;
         m_sa = sa; m_ta = ta; m_da = ifid_ir[15:11];
         m_s = sv; m_t = tv;
         m_se = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
         m_pc = isr ? ifid_pc - 32'd8 : ifid_pc;
         m_ja = {ifid_pc[31:28], ifid_ir[25:0], 2'b00};
      end
      if (wb_en && wb_addr != 0) mreg[wb_addr] = wb_data;
      check_all(where);
   endtask

   task automatic idle();
      ifid_ir = 0; ifid_pc = 0; ifid_vld = 0; isr = 0; lisr = 0;
      ctl_ex = 0; ctl_m = 0; ctl_wb = 0; flush = 0; ex_stall = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0;
   endtask

   function automatic logic [31:0] mk_ir(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [10:0] lo);
      return {6'h00, rs, rt, rd, lo};
   endfunction

   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      #12 rst = 1'b0;
      @(posedge clk); #1;

      // reset state
      chk("rst.vld", 64'(idex_vld), 64'd0);
      chk("rst.s", 64'(idex_s), 64'd0);
      chk("rst.pc", 64'(idex_pc), 64'd0);
      chk("rst.cnt", 64'(bubble_cnt), 64'd0);
      chk("rst.stall", 64'(id_stall), 64'd0);
      check_all("rst");

      // SP initial value
      ifid_vld = 1; ifid_ir = mk_ir(5'd29, 5'd0, 5'd0, 11'd0);
      cycle("sp");
      chk("sp.value", 64'(idex_s), 64'h3FC);

      // write-through bypass
      wb_en = 1; wb_addr = 5'd5; wb_data = 32'hDEAD;
      ifid_ir = mk_ir(5'd5, 5'd0, 5'd0, 11'd0);
      cycle("byp");
      chk("byp.s", 64'(idex_s), 64'hDEAD);

      // register 0 ignores writes
      wb_addr = 5'd0; wb_data = 32'h1234;
      ifid_ir = mk_ir(5'd0, 5'd0, 5'd0, 11'd0);
      cycle("r0");
      chk("r0.s", 64'(idex_s), 64'h0);
      wb_en = 0;

      // load-use: lw rt=8 then add reading 8
      ctl_m = 16'h0001; ifid_ir = {6'h23, 5'd0, 5'd8, 16'h0004};
      cycle("lw");
      ctl_m = 16'h0000; ifid_ir = mk_ir(5'd8, 5'd9, 5'd10, 11'h020);
      cycle("lu1");
      chk("lu1.stall", 64'(obs_stall), 64'd1);
      chk("lu1.vld", 64'(idex_vld), 64'd0);
      chk("lu1.cnt", 64'(bubble_cnt), 64'd1);
      cycle("lu2");
      chk("lu2.stall", 64'(obs_stall), 64'd0);
      chk("lu2.vld", 64'(idex_vld), 64'd1);
      chk("lu2.sa", 64'(idex_sa), 64'd8);
      chk("lu2.cnt", 64'(bubble_cnt), 64'd1);

      // flush beats ex_stall and load_use
      ctl_m = 16'h0001; ifid_ir = {6'h23, 5'd0, 5'd8, 16'h0004};
      cycle("lw2");
      ctl_m = 16'h0000; ifid_ir = mk_ir(5'd8, 5'd9, 5'd10, 11'h020);
      flush = 1; ex_stall = 1;
      cycle("fl");
      chk("fl.stall", 64'(obs_stall), 64'd1);
      chk("fl.vld", 64'(idex_vld), 64'd0);
      chk("fl.m", 64'(idex_m), 64'd0);
      chk("fl.cnt", 64'(bubble_cnt), 64'd1);
      flush = 0; ex_stall = 0;

      // interrupt entry / exit
      isr = 1; ifid_pc = 32'h100; ifid_ir = mk_ir(5'd3, 5'd4, 5'd0, 11'd0);
      cycle("isr");
      chk("isr.pc", 64'(idex_pc), 64'hF8);
      chk("isr.sa", 64'(idex_sa), 64'd29);
      isr = 0; lisr = 3'b010;
      cycle("lisr");
      chk("lisr.pc", 64'(idex_pc), 64'h100);
      chk("lisr.sa", 64'(idex_sa), 64'd29);
      lisr = 0;

      // jump address and sign extension
      ifid_ir = 32'h0800_0040; ifid_pc = 32'hA000_0000;
      cycle("ja");
      chk("ja.ja", 64'(idex_ja), 64'hA000_0100);
      chk("ja.se", 64'(idex_se), 64'h40);
      ifid_ir = 32'h0000_8000;
      cycle("se");
      chk("se.se", 64'(idex_se), 64'hFFFF_8000);

      // reset asserted while held by ex_stall
      ex_stall = 1; ctl_ex = 16'hBEEF;
      cycle("hold");
      #2 rst = 1'b1; ex_stall = 0;
      #1;
      model_reset();
      chk("rstmid.vld", 64'(idex_vld), 64'd0);
      chk("rstmid.pc", 64'(idex_pc), 64'd0);
      chk("rstmid.cnt", 64'(bubble_cnt), 64'd0);
      chk("rstmid.stall", 64'(id_stall), 64'd0);
      @(posedge clk); #3 rst = 1'b0;
      idle();
      @(posedge clk); #1;
      check_all("post_rst");

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         ifid_ir  = $urandom;
         ifid_ir[25:21] = 5'($urandom_range(0, 7));
         ifid_ir[20:16] = 5'($urandom_range(0, 7));
         ifid_pc  = $urandom;
         ifid_vld = ($urandom_range(0, 5) != 0);
         isr      = ($urandom_range(0, 9) == 0);
         lisr     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
         ctl_ex   = 16'($urandom);
         ctl_m    = 16'($urandom);
         ctl_wb   = 4'($urandom);
         flush    = ($urandom_range(0, 9) == 0);
         ex_stall = ($urandom_range(0, 6) == 0);
         wb_en    = $urandom_range(0, 1) == 1;
         wb_addr  = 5'($urandom_range(0, 7));
         wb_data  = $urandom;
         cycle("rnd");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
